// File: rtl/uart_reply_tx.sv
// Reply serializer: paces a captured payload plus CR/NL into the UART transmit handshake.
// Optional build macro UART_REPLY_HEX_EN sends each payload byte as two uppercase ASCII hex characters.
module uart_reply_tx #(
  parameter int MAX_BYTES     = 16,
  parameter int LEN_W         = 5,
  parameter int START_TIMEOUT = 64
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [8*MAX_BYTES-1:0] req_data,
  input  logic [LEN_W-1:0]       req_len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   transmit,
  output logic [7:0]             tx_byte,
  input  logic                   is_transmitting
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [LEN_W:0]   MAX_LEN  = (LEN_W + 1)'(MAX_BYTES);
  localparam logic [LEN_W:0]   IDX_ONE  = (LEN_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [7:0]       CHAR_CR  = 8'h0d;
  localparam logic [7:0]       CHAR_NL  = 8'h0a;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_STROBE    = 3'd2,
    S_WAIT_RISE = 3'd3,
    S_WAIT_FALL = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  function automatic logic [7:0] pick_byte(input logic [8*MAX_BYTES-1:0] data,
                                           input logic [LEN_W:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (idx == (LEN_W + 1)'(k)) b = data[8*k +: 8];
      else                        b = b;
    end
    return b;
  endfunction

`ifdef UART_REPLY_HEX_EN
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction
`endif

  state_t                 state_r, state_next_s;
  logic [8*MAX_BYTES-1:0] data_r, data_next_s;
  logic [LEN_W:0]         len_r, len_next_s, idx_r, idx_next_s;
  logic [CNT_W-1:0]       cnt_r, cnt_next_s;
  logic                   err_flag_r, err_flag_next_s;
  logic                   busy_r, busy_next_s, done_r, done_next_s, err_r, err_next_s;
  logic                   transmit_r, transmit_next_s;
  logic [7:0]             tx_byte_r, tx_byte_next_s;
  logic [7:0]             payload_byte_s, payload_char_s;
  logic                   char_done_s;
`ifdef UART_REPLY_HEX_EN
  logic                   sub_r, sub_next_s;
`endif

  // Next-state and datapath next values for the whole frame sequencer.
  always_comb begin
    state_next_s    = state_r;
    data_next_s     = data_r;
    len_next_s      = len_r;
    idx_next_s      = idx_r;
    cnt_next_s      = cnt_r;
    err_flag_next_s = err_flag_r;
    busy_next_s     = busy_r;
    done_next_s     = 1'b0;
    err_next_s      = 1'b0;
    transmit_next_s = 1'b0;
    tx_byte_next_s  = tx_byte_r;
    char_done_s     = 1'b0;
    payload_byte_s  = pick_byte(data_r, idx_r);
`ifdef UART_REPLY_HEX_EN
    sub_next_s      = sub_r;
    payload_char_s  = hex_char(sub_r ? payload_byte_s[3:0] : payload_byte_s[7:4]);
`else
    payload_char_s  = payload_byte_s;
`endif

    case (state_r)
      S_IDLE: begin
        if (req) begin
          data_next_s     = req_data;
          len_next_s      = ({1'b0, req_len} > MAX_LEN) ? MAX_LEN : {1'b0, req_len};
          idx_next_s      = {(LEN_W + 1){1'b0}};
          cnt_next_s      = {CNT_W{1'b0}};
          err_flag_next_s = 1'b0;
          busy_next_s     = 1'b1;
          state_next_s    = S_LOAD;
`ifdef UART_REPLY_HEX_EN
          sub_next_s      = 1'b0;
`endif
        end else begin
          state_next_s = S_IDLE;
        end
      end
      // Payload characters first, then CR, then NL; idx runs past len to walk the terminator.
      S_LOAD: begin
        if (idx_r < len_r) begin
          tx_byte_next_s  = payload_char_s;
          transmit_next_s = 1'b1;
          state_next_s    = S_STROBE;
        end else if (idx_r == len_r) begin
          tx_byte_next_s  = CHAR_CR;
          transmit_next_s = 1'b1;
          state_next_s    = S_STROBE;
        end else if (idx_r == len_r + IDX_ONE) begin
          tx_byte_next_s  = CHAR_NL;
          transmit_next_s = 1'b1;
          state_next_s    = S_STROBE;
        end else begin
          done_next_s     = 1'b1;
          err_next_s      = err_flag_r;
          err_flag_next_s = 1'b0;
          state_next_s    = S_DONE;
        end
      end
      S_STROBE: begin
        cnt_next_s   = {CNT_W{1'b0}};
        state_next_s = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (is_transmitting) begin
          state_next_s = S_WAIT_FALL;
        end else if (cnt_r == CNT_LAST) begin
          err_flag_next_s = 1'b1;
          char_done_s     = 1'b1;
          state_next_s    = S_LOAD;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      S_WAIT_FALL: begin
        if (!is_transmitting) begin
          char_done_s  = 1'b1;
          state_next_s = S_LOAD;
        end else begin
          state_next_s = S_WAIT_FALL;
        end
      end
      S_DONE: begin
        busy_next_s  = 1'b0;
        state_next_s = S_IDLE;
      end
      default: begin
        busy_next_s  = 1'b0;
        state_next_s = S_IDLE;
      end
    endcase

    if (char_done_s) begin
`ifdef UART_REPLY_HEX_EN
      if ((idx_r < len_r) && !sub_r) begin
        sub_next_s = 1'b1;
      end else begin
        sub_next_s = 1'b0;
        idx_next_s = idx_r + IDX_ONE;
      end
`else
      idx_next_s = idx_r + IDX_ONE;
`endif
    end else begin
      idx_next_s = idx_next_s;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_next_s;
  end

  // Datapath and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= {(8 * MAX_BYTES){1'b0}};
      len_r      <= {(LEN_W + 1){1'b0}};
      idx_r      <= {(LEN_W + 1){1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      err_flag_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      transmit_r <= 1'b0;
      tx_byte_r  <= 8'h00;
`ifdef UART_REPLY_HEX_EN
      sub_r      <= 1'b0;
`endif
    end else begin
      data_r     <= data_next_s;
      len_r      <= len_next_s;
      idx_r      <= idx_next_s;
      cnt_r      <= cnt_next_s;
      err_flag_r <= err_flag_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      err_r      <= err_next_s;
      transmit_r <= transmit_next_s;
      tx_byte_r  <= tx_byte_next_s;
`ifdef UART_REPLY_HEX_EN
      sub_r      <= sub_next_s;
`endif
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign transmit = transmit_r;
  assign tx_byte  = tx_byte_r;

endmodule

// File: tb/tb_uart_reply_tx.sv
// Scoreboard bench for uart_reply_tx: expected characters are queued at request time and
// popped on every transmit strobe; a simple UART model answers the handshake.
module tb_uart_reply_tx;

  localparam int MB    = 16;
  localparam int LEN_W = 5;
  localparam int TO    = 64;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic [8*MB-1:0]   req_data;
  logic [LEN_W-1:0]  req_len;
  logic              busy, done, err, transmit;
  logic [7:0]        tx_byte;
  logic              is_transmitting;

  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                strobes = 0;
  int                done_cnt = 0;
  int                err_cnt = 0;
  int                uart_cnt;
  logic              uart_live;
  logic [7:0]        exp_q[$];
  int                strobe_cyc[$];
  logic [7:0]        mon_exp;

  uart_reply_tx #(.MAX_BYTES(MB), .LEN_W(LEN_W), .START_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_len(req_len),
    .busy(busy), .done(done), .err(err), .transmit(transmit), .tx_byte(tx_byte),
    .is_transmitting(is_transmitting)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model: busy for 10 cycles starting the cycle after a strobe, or silent when not live.
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_cnt <= 0;
      is_transmitting <= 1'b0;
    end else if (transmit && uart_live) begin
      uart_cnt <= 10;
      is_transmitting <= 1'b1;
    end else if (uart_cnt > 1) begin
      uart_cnt <= uart_cnt - 1;
    end else begin
      uart_cnt <= 0;
      is_transmitting <= 1'b0;
    end
  end

  // Monitor: every strobe must match the head of the scoreboard queue.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (transmit) begin
        strobes++;
        strobe_cyc.push_back(cyc);
        check("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check("tx_byte", {24'd0, tx_byte}, {24'd0, mon_exp});
        end
      end
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        check("err_needs_done", {31'd0, done}, 32'd1);
      end
    end
  end

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  task automatic push_byte(input logic [7:0] b);
`ifdef UART_REPLY_HEX_EN
    exp_q.push_back(hex_ch(b[7:4]));
    exp_q.push_back(hex_ch(b[3:0]));
`else
    exp_q.push_back(b);
`endif
  endtask

  task automatic send_req(input logic [LEN_W-1:0] len, input logic [8*MB-1:0] data);
    @(negedge sys_clk);
    req_data = data;
    req_len  = len;
    req      = 1'b1;
    @(negedge sys_clk);
    req      = 1'b0;
    req_data = {4{$urandom}};
    req_len  = LEN_W'($urandom);
    check("busy_after_req", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget, input logic exp_err);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge sys_clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("err_at_done", {31'd0, err}, {31'd0, exp_err});
      check("busy_at_done", {31'd0, busy}, 32'd1);
    end
    @(negedge sys_clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input logic [LEN_W-1:0] len, input logic [8*MB-1:0] data,
                           input logic exp_err);
    int nb, nexp, base_s, base_d;
    nb = (int'(len) > MB) ? MB : int'(len);
    for (int k = 0; k < nb; k++) push_byte(data[8*k +: 8]);
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
    nexp   = exp_q.size();
    base_s = strobes;
    base_d = done_cnt;
    send_req(len, data);
    wait_done(2000, exp_err);
    check("strobe_count", strobes - base_s, nexp);
    check("queue_drained", exp_q.size(), 32'd0);
    check("done_pulses", done_cnt - base_d, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*MB-1:0] d;
    int seen, base_s, base_d, base_e;
    logic pulsed;

    rst_n = 1'b0; req = 1'b0; req_data = {(8*MB){1'b0}}; req_len = {LEN_W{1'b0}};
    uart_live = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_transmit", {31'd0, transmit}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Three-byte payload, the last byte equal to CR.
    d = {(8*MB){1'b0}};
    d[23:0] = 24'h0DA504;
    run_frame(5'd3, d, 1'b0);

    // Empty payload: terminator only.
    run_frame(5'd0, {4{$urandom}}, 1'b0);

    // Oversized length clamps to MAX_BYTES.
    run_frame(5'd20, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Silent UART: every character times out, err pulses with done.
    uart_live = 1'b0;
    strobe_cyc.delete();
    base_e = err_cnt;
    d = {(8*MB){1'b0}};
    d[7:0] = 8'hC3;
    run_frame(5'd1, d, 1'b1);
    for (int k = 1; k < strobe_cyc.size(); k++)
      check("timeout_gap", strobe_cyc[k] - strobe_cyc[k-1], TO + 2);
    check("timeout_err_pulses", err_cnt - base_e, 32'd1);
    uart_live = 1'b1;

    // Ignored second request, then reset at the second character.
    d = {(8*MB){1'b0}};
    d[23:0] = 24'h332211;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    base_s = strobes;
    base_d = done_cnt;
    send_req(5'd3, d);
    seen = 0;
    pulsed = 1'b0;
    for (int n = 0; n < 500 && seen < 2; n++) begin
      @(negedge sys_clk);
      req = 1'b0;
      if (transmit) seen++;
      if (seen == 1 && !pulsed) begin
        req = 1'b1; req_len = 5'd2; req_data = {4{32'h77777777}};
        pulsed = 1'b1;
      end
    end
    req = 1'b0;
    check("second_strobe_seen", seen, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("abort_transmit", {31'd0, transmit}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_tx_byte", {24'd0, tx_byte}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (30) @(negedge sys_clk);
    check("abort_strobes", strobes - base_s, 32'd2);
    check("abort_no_done", done_cnt - base_d, 32'd0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    d = {(8*MB){1'b0}};
    d[7:0] = 8'h5A;
    run_frame(5'd1, d, 1'b0);

    // 0x3F: raw, or '3','F' when hex encoding is built in.
    d = {(8*MB){1'b0}};
    d[7:0] = 8'h3F;
    run_frame(5'd1, d, 1'b0);

    repeat (2) @(negedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
